// File: rtl/bcd2bin_seq_if.sv
// ============================================================================
//  Module      : bcd2bin_seq_if
//  Description : start/busy/done request bundle for the BCD-to-binary converter
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd2bin_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err
  );
endinterface

`default_nettype wire

// File: rtl/bcd2bin_seq.sv
// ============================================================================
//  Module      : bcd2bin_seq
//  Description : sequential BCD-to-binary converter, reverse double dabble
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd2bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  bcd2bin_seq_if.slave    bus
);

  localparam int c_bcd_w = 4 * DIGITS;
  localparam int c_cnt_w = $clog2(BIN_W + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BIN_W - 1);

  localparam logic [0:0] c_idle  = 1'b0;
  localparam logic [0:0] c_shift = 1'b1;

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [c_bcd_w-1:0]  r_bcd_sr;
  logic [BIN_W-1:0]    r_bin_sr;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [BIN_W-1:0]    r_bin_out;
  logic                r_err;
  logic                r_done;
  logic                w_busy;

  logic [c_bcd_w-1:0]  w_bcd_sh;
  logic [c_bcd_w-1:0]  w_bcd_fix;
  logic [BIN_W-1:0]    w_bin_sh;
  logic [DIGITS-1:0]   w_dig_bad;
  logic                w_bad;
  logic                w_last;

  assign w_bcd_sh = {1'b0, r_bcd_sr[c_bcd_w-1:1]};
  assign w_bin_sh = {r_bcd_sr[0], r_bin_sr[BIN_W-1:1]};
  assign w_bad    = |w_dig_bad;
  assign w_last   = (r_cnt == c_last);

  // A digit that reads >= 8 after the shift held an odd tens-weight bit; subtract 3 to re-weight.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] w_d;
      assign w_d = w_bcd_sh[4*i +: 4];
      assign w_bcd_fix[4*i +: 4] = w_d[3] ? (w_d - 4'd3) : w_d;
      assign w_dig_bad[i] = bus.bcd_in[4*i+3] & (bus.bcd_in[4*i+2] | bus.bcd_in[4*i+1]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (bus.start && !w_bad) w_state_nxt = c_shift;
      c_shift: if (w_last) w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    if (r_state == c_shift) w_busy = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bcd_sr  <= '0;
      r_bin_sr  <= '0;
      r_cnt     <= '0;
      r_bin_out <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (bus.start) begin
            if (w_bad) begin
              r_bin_out <= '0;
              r_err     <= 1'b1;
              r_done    <= 1'b1;
            end else begin
              r_bcd_sr <= bus.bcd_in;
              r_bin_sr <= '0;
              r_cnt    <= '0;
            end
          end
        end
        c_shift: begin
          r_bcd_sr <= w_bcd_fix;
          r_bin_sr <= w_bin_sh;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_bin_out <= w_bin_sh;
            r_err     <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.bin_out = r_bin_out;
  assign bus.err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
// ============================================================================
//  Module      : tb_bcd2bin_seq
//  Description : scoreboard bench for bcd2bin_seq (3-digit and 2-digit builds)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd2bin_seq;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;

  logic [10:0] exp_q[$];   // {err, bin_out}

  bcd2bin_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();
  bcd2bin_seq_if #(.DIGITS(2), .BIN_W(7))  bus2 ();

  bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  bcd2bin_seq #(.DIGITS(2), .BIN_W(7)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", bus.done, 0);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        check("bin_out", bus.bin_out, e[9:0]);
        check("err", bus.err, e[10]);
      end
    end
  end

  // Waits (bounded) from just after an accepting edge until done is seen.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", bus.done, 1);
  endtask

  task automatic request(input logic [11:0] bcd, input int exp_bin, input logic exp_err);
    int n, nb;
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    exp_q.push_back({exp_err, 10'(exp_bin)});
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.bcd_in = ~bcd;
    if (exp_err) check("busy_on_invalid", bus.busy, 0);
    wait_done(n, nb);
    check("latency", n, exp_err ? 0 : 10);
    check("busy_cycles", nb, exp_err ? 0 : 10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, nb, t1, t2, t3;
    logic [11:0] inv;
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.bcd_in  = '0;
    bus2.start  = 1'b0;
    bus2.bcd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_bin_out", bus.bin_out, 0);
    check("rst_err", bus.err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    request(12'h999, 999, 1'b0);
    request(12'h000, 0,   1'b0);
    request(12'h255, 255, 1'b0);
    request(12'h100, 100, 1'b0);
    request(12'h009, 9,   1'b0);
    request(12'h090, 90,  1'b0);

    request(12'h1A3, 0,  1'b1);
    request(12'h042, 42, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("bin_out_hold", bus.bin_out, 42);

    // start held high; bcd_in changed while the first conversion runs
    bus.start  = 1'b1;
    bus.bcd_in = 12'h123;
    exp_q.push_back({1'b0, 10'd123});
    @(posedge clk); #1;
    bus.bcd_in = 12'h456;
    exp_q.push_back({1'b0, 10'd456});
    wait_done(n, nb);
    t1 = cyc;
    @(posedge clk); #1;
    bus.bcd_in = 12'h789;
    exp_q.push_back({1'b0, 10'd789});
    wait_done(n, nb);
    t2 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(n, nb);
    t3 = cyc;
    check("b2b_period1", t2 - t1, 11);
    check("b2b_period2", t3 - t2, 11);
    @(posedge clk); #1;

    // reset at shift 5 of a 0x777 conversion
    bus.start  = 1'b1;
    bus.bcd_in = 12'h777;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_bin_out", bus.bin_out, 0);
    check("abort_err", bus.err, 0);
    repeat (15) @(posedge clk);
    #1;
    request(12'h777, 777, 1'b0);

    for (int v = 0; v < 1000; v++) request(to_bcd(v), v, 1'b0);

    for (int i = 0; i < 20; i++) begin
      int pos;
      inv = 12'($urandom_range(0, 4095));
      pos = $urandom_range(0, 2);
      inv[4*pos +: 4] = 4'($urandom_range(10, 15));
      request(inv, 0, 1'b1);
    end

    // 2-digit build
    for (int k = 0; k < 2; k++) begin
      logic [7:0] b;
      int ev;
      b  = (k == 0) ? 8'h99 : 8'h47;
      ev = (k == 0) ? 99 : 47;
      bus2.start  = 1'b1;
      bus2.bcd_in = b;
      @(posedge clk); #1;
      bus2.start  = 1'b0;
      bus2.bcd_in = 8'h00;
      n = 0;
      while (!bus2.done && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      check("d2_latency", n, 7);
      check("d2_bin_out", bus2.bin_out, ev);
      check("d2_err", bus2.err, 0);
      @(posedge clk); #1;
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
